ifu: RTL
========

IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL provide a parameter RESET_PC, default 32'h0000_3000, giving the byte address of the first fetch after reset.
REQ-002 clk  input  1  the single rising-edge clock for all state.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request to the instruction memory; held high until a response arrives.
REQ-005 imem_addr  output  32  byte address of the requested word; equals fetch PC while imem_req=1.
REQ-006 imem_rvalid  input  1  instruction memory response valid; may assert in the same cycle as imem_req (zero-wait).
REQ-007 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-008 instr  output  32  held instruction word presented to the decoder.
REQ-009 instr_valid  output  1  instr/pc/pc_plus4 are valid.
REQ-010 instr_ready  input  1  downstream accepts and retires the presented instruction this cycle.
REQ-011 pc  output  32  address of instr; pc_plus4  output  32  pc+4, the link value for jal.
REQ-012 next_pc_op  input  3  decoder redirect code: 0 sequential, 1 beq, 2 jal, 3 jr, 4-7 treated as 0.
REQ-013 cmp_eq  input  1  beq taken condition; imm  input  16  branch offset; j_address  input  26  jump index; jr_target  input  32  register jump target.
REQ-014 retire_cnt  output  32  number of retired instructions.
REQ-015 fetch_err  output  1  sticky fetch-address error (see Configuration).

Function
REQ-016 The FSM SHALL have states FETCH, VALID, ERR; ERR is reachable only when IFU_ALIGN_CHECK_EN is defined.
REQ-017 FETCH: imem_req=1, imem_addr=fetch PC, instr_valid=0; on imem_rvalid=1 latch imem_rdata into instr and go to VALID at the next edge.
REQ-018 VALID: imem_req=0, instr_valid=1, instr/pc stable; while instr_ready=0 stay in VALID with all outputs unchanged.
REQ-019 A retire SHALL occur exactly on a cycle with instr_valid=1 and instr_ready=1; at that edge pc <= next PC, retire_cnt <= retire_cnt+1, state <= FETCH.
REQ-020 next_pc_op, cmp_eq, imm, j_address, jr_target SHALL be sampled only on the retire cycle; values on other cycles are ignored.
REQ-021 Next PC: op 0/4-7 -> pc+4; op 1 -> cmp_eq ? pc+4+(sign_ext(imm)<<2) : pc+4; op 2 -> {pc[31:28], j_address, 2'b00}; op 3 -> jr_target.
REQ-022 All PC arithmetic SHALL be modulo 2^32 (wrap, no overflow flag); retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-023 imem_rvalid outside FETCH SHALL be ignored; minimum latency imem_req rise -> instr_valid is 1 cycle; peak throughput one retire per 2 cycles.
REQ-024 pc_plus4 SHALL be combinationally pc+4 at all times.

Reset
REQ-025 While reset_n=0: state=FETCH, pc=RESET_PC, instr=0, retire_cnt=0, fetch_err=0, instr_valid=0; imem_req=1 in the first cycle after reset_n rises.
REQ-026 Reset asserted mid-wait or mid-VALID SHALL abandon the transaction immediately; a late imem_rvalid in the cycle of release is treated as the response to the new fetch of RESET_PC.

Configuration
REQ-027 Macro IFU_ALIGN_CHECK_EN defined: a computed next PC with bits [1:0]!=0 SHALL, at the retire edge, send the FSM to ERR: imem_req=0, instr_valid=0, fetch_err=1, pc=offending address, held until reset.
REQ-028 Macro IFU_ALIGN_CHECK_EN undefined: next PC bits [1:0] SHALL be forced to 0, ERR state absent, fetch_err tied 0.

Verification
REQ-029 Reset release, memory returns 32'h3402_0005 with rvalid same cycle, ready=1 -> imem_addr=32'h3000, instr_valid next cycle, retire_cnt=1, next imem_addr=32'h3004.
REQ-030 pc=32'h3008, next_pc_op=1, cmp_eq=1, imm=16'hFFFE, retire -> next imem_addr=32'h3004; same with cmp_eq=0 -> 32'h300C.
REQ-031 pc=32'h3010, next_pc_op=2, j_address=26'h0000C10 -> next imem_addr=32'h0000_3040, pc_plus4=32'h3014 during VALID.
REQ-032 rvalid delayed 3 cycles, then instr_ready=0 for 4 cycles -> imem_req high 4 cycles, instr/pc stable, retire_cnt unchanged until ready.
REQ-033 next_pc_op=3, jr_target=32'h3002 -> with IFU_ALIGN_CHECK_EN: fetch_err=1, imem_req=0 until reset; without: next imem_addr=32'h3000.
REQ-034 reset_n pulsed low while in VALID at pc=32'h3020 -> pc=32'h3000, instr_valid=0 immediately, retire_cnt=0.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word, holds it for decode, and computes the next PC at retire. Optional IFU_ALIGN_CHECK_EN traps misaligned targets.
// Latency: instr_valid rises 1 cycle after imem_req when memory answers zero-wait, so at most one retire every 2 cycles.
// Backpressure: while instr_ready=0 the instruction, pc and counters hold in VALID, and no new fetch is issued.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [2:0]  next_pc_op,
  input  logic        cmp_eq,
  input  logic [15:0] imm,
  input  logic [25:0] j_address,
  input  logic [31:0] jr_target,
  output logic [31:0] retire_cnt,
  output logic        fetch_err
);

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, VALID, ERR} state_t;
`else
  typedef enum logic [1:0] {FETCH, VALID} state_t;
`endif

  state_t      state;
  logic        retire;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;

  assign retire    = (state == VALID) && instr_ready;
  assign imem_req  = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    seq_pc = pc + 32'd4;
    br_pc  = seq_pc + {{14{imm[15]}}, imm, 2'b00};
    case (next_pc_op)
      3'd1:    next_pc_raw = cmp_eq ? br_pc : seq_pc;
      3'd2:    next_pc_raw = {pc[31:28], j_address, 2'b00};
      3'd3:    next_pc_raw = jr_target;
      default: next_pc_raw = seq_pc;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign next_pc = next_pc_raw;
`else
  // Without the trap, a misaligned target is silently rounded down to a word.
  assign next_pc = next_pc_raw & ~32'h3;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      instr      <= 32'h0;
      retire_cnt <= 32'h0;
`ifdef IFU_ALIGN_CHECK_EN
      fetch_err  <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= VALID;
          end
        end
        VALID: begin
          if (retire) begin
            retire_cnt <= retire_cnt + 32'd1;
            pc         <= next_pc;
`ifdef IFU_ALIGN_CHECK_EN
            if (next_pc[1:0] != 2'b00) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end else begin
              state <= FETCH;
            end
`else
            state <= FETCH;
`endif
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        ERR: state <= ERR;
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule
